// File: rtl/alu_pipe.sv
// Two-stage pipelined WIDTH-bit ALU (ADD/SUB/INC/AND) with valid/ready handshake,
// multi-word carry chaining through an internal carry register, and Z/N/sticky-overflow flags.
module alu_pipe #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [1:0]       op,
    input  logic             chain,
    input  logic             clr_sticky,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cf,
    output logic             of,
    output logic             zf,
    output logic             nf,
    output logic             sticky_of
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_INC = 2'b10,
        OP_AND = 2'b11
    } op_e;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;
    op_e              r_s1_op;
    logic             r_s1_chain;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_cf;
    logic             r_of;
    logic             r_zf;
    logic             r_nf;
    logic             r_sticky;
    logic             r_carry;

    logic             w_s2_adv;
    logic             w_in_ready;
    logic             w_xfer;
    logic [WIDTH-1:0] w_y;
    logic             w_c0;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_res;
    logic             w_cf;
    logic             w_of;

    assign w_s2_adv   = !r_out_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s2_adv;
    assign w_xfer     = r_s1_valid && w_s2_adv;

    // Carry into the MSB is recovered as a^y^sum at that bit, so overflow = c_msb ^ c_out.
    always_comb begin
        w_y   = r_s1_b;
        w_c0  = 1'b0;
        case (r_s1_op)
            OP_ADD: begin
                w_y  = r_s1_b;
                w_c0 = r_s1_chain ? r_carry : r_s1_cin;
            end
            OP_SUB: begin
                w_y  = ~r_s1_b;
                w_c0 = r_s1_chain ? r_carry : 1'b1;
            end
            OP_INC: begin
                w_y  = '0;
                w_c0 = 1'b1;
            end
            default: begin
                w_y  = r_s1_b;
                w_c0 = 1'b0;
            end
        endcase
        w_sum = {1'b0, r_s1_a} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_c0};
        if (r_s1_op == OP_AND) begin
            w_res = r_s1_a & r_s1_b;
            w_cf  = 1'b0;
            w_of  = 1'b0;
        end else begin
            w_res = w_sum[WIDTH-1:0];
            w_cf  = w_sum[WIDTH];
            w_of  = r_s1_a[WIDTH-1] ^ w_y[WIDTH-1] ^ w_sum[WIDTH-1] ^ w_sum[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cin   <= 1'b0;
            r_s1_op    <= OP_ADD;
            r_s1_chain <= 1'b0;
        end else if (in_valid && w_in_ready) begin
            r_s1_valid <= 1'b1;
            r_s1_a     <= a;
            r_s1_b     <= b;
            r_s1_cin   <= cin;
            r_s1_op    <= op_e'(op);
            r_s1_chain <= chain;
        end else if (w_xfer) begin
            r_s1_valid <= 1'b0;
        end
    end

    // A chained beat entering S1 on the same edge sees the updated carry one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_cf        <= 1'b0;
            r_of        <= 1'b0;
            r_zf        <= 1'b0;
            r_nf        <= 1'b0;
            r_carry     <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_s         <= w_res;
            r_cf        <= w_cf;
            r_of        <= w_of;
            r_zf        <= (w_res == '0);
            r_nf        <= w_res[WIDTH-1];
            if (r_s1_op != OP_AND) begin
                r_carry <= w_cf;
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
        end else if (w_xfer && w_of) begin
            r_sticky <= 1'b1;
        end else if (clr_sticky) begin
            r_sticky <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cf        = r_cf;
    assign of        = r_of;
    assign zf        = r_zf;
    assign nf        = r_nf;
    assign sticky_of = r_sticky;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: expected results queued on accept, compared on output handshake.
module tb_alu_pipe;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [1:0]   op = 2'b00;
    logic         chain = 1'b0;
    logic         clr_sticky = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         cf, of, zf, nf, sticky_of;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cf;
        logic         of;
        logic         zf;
        logic         nf;
    } res_t;

    res_t q[$];
    logic model_carry = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   n_out = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .op(op), .chain(chain), .clr_sticky(clr_sticky),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cf(cf), .of(of),
        .zf(zf), .nf(nf), .sticky_of(sticky_of)
    );

    always #5 clk = ~clk;

    task automatic push_exp(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] yb,
                            input logic ci, input logic ch);
        res_t r;
        logic [W-1:0] y;
        int c0;
        int full;
        c0 = 0;
        y  = yb;
        case (o)
            2'b00: begin y = yb;  c0 = ch ? int'(model_carry) : int'(ci); end
            2'b01: begin y = ~yb; c0 = ch ? int'(model_carry) : 1; end
            2'b10: begin y = '0;  c0 = 1; end
            default: ;
        endcase
        if (o == 2'b11) begin
            r.s  = x & yb;
            r.cf = 1'b0;
            r.of = 1'b0;
        end else begin
            full = int'(x) + int'(y) + c0;
            r.s  = full[W-1:0];
            r.cf = full[W];
            r.of = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
            model_carry = r.cf;
        end
        r.zf = (r.s == 0);
        r.nf = r.s[W-1];
        q.push_back(r);
    endtask

    // Inputs change 1 time unit after a rising edge; acceptance is sampled at the falling edge.
    task automatic send(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic ch);
        int n;
        bit done;
        op = o; a = x; b = y; cin = ci; chain = ch;
        in_valid = 1'b1;
        n = 0;
        done = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(o, x, y, ci, ch);
                @(posedge clk);
                #1;
                done = 1;
            end else if (n > 60) begin
                tests++;
                fails++;
                $display("FAIL send_timeout: in_ready stayed 0, required 1 within 60 cycles");
                done = 1;
            end else begin
                n++;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain;
        int n;
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            res_t got;
            res_t exp;
            got = '{s: s, cf: cf, of: of, zf: zf, nf: nf};
            n_out++;
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL result_unexpected: got s=%h cf=%b of=%b zf=%b nf=%b, required no output",
                         s, cf, of, zf, nf);
            end else begin
                exp = q.pop_front();
                if (got !== exp) begin
                    fails++;
                    $display("FAIL result: got s=%h cf=%b of=%b zf=%b nf=%b, required s=%h cf=%b of=%b zf=%b nf=%b",
                             got.s, got.cf, got.of, got.zf, got.nf, exp.s, exp.cf, exp.of, exp.zf, exp.nf);
                end
            end
        end
    end

    task automatic test_reset;
        #3;
        tests++;
        if ({out_valid, s, cf, of, zf, nf, sticky_of, in_ready} !== {1'b0, 8'h00, 5'b00000, 1'b1}) begin
            fails++;
            $display("FAIL reset_state: got ov=%b s=%h flags=%b%b%b%b st=%b ir=%b, required ov=0 s=00 flags=0000 st=0 ir=1",
                     out_valid, s, cf, of, zf, nf, sticky_of, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency;
        out_ready = 1'b1;
        send(2'b00, 8'h10, 8'h20, 1'b1, 1'b0);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL latency_early: out_valid=%b one cycle after accept, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        tests++;
        if (out_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency: out_valid=%b two cycles after accept, required 1", out_valid);
        end
        drain();
    endtask

    task automatic test_arith;
        out_ready = 1'b1;
        send(2'b00, 8'h7F, 8'h01, 1'b0, 1'b0);
        drain();
        tests++;
        if (sticky_of !== 1'b1) begin
            fails++;
            $display("FAIL sticky_set: sticky_of=%b, required 1", sticky_of);
        end
        send(2'b01, 8'h05, 8'h05, 1'b0, 1'b0);
        send(2'b01, 8'h00, 8'h01, 1'b0, 1'b0);
        send(2'b01, 8'h05, 8'h02, 1'b0, 1'b1);
        send(2'b10, 8'hFF, 8'h00, 1'b0, 1'b0);
        send(2'b11, 8'hF0, 8'h3C, 1'b0, 1'b0);
        send(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
        send(2'b00, 8'h80, 8'h80, 1'b0, 1'b0);
        drain();
    endtask

    task automatic test_clr_sticky;
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        tests++;
        if (sticky_of !== 1'b0) begin
            fails++;
            $display("FAIL sticky_clear: sticky_of=%b, required 0", sticky_of);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        send(2'b00, 8'hFF, 8'h01, 1'b0, 1'b0);
        send(2'b00, 8'h00, 8'h00, 1'b0, 1'b1);
        send(2'b01, 8'h10, 8'h20, 1'b0, 1'b0);
        send(2'b01, 8'h00, 8'h00, 1'b0, 1'b1);
        drain();
    endtask

    task automatic test_backpressure;
        int start;
        res_t first;
        start = n_out;
        out_ready = 1'b0;
        send(2'b00, 8'h11, 8'h22, 1'b0, 1'b0);
        send(2'b01, 8'h50, 8'h30, 1'b0, 1'b0);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_in_ready: in_ready=%b after two buffered beats, required 0", in_ready);
        end
        first = q[0];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || s !== first.s) begin
                fails++;
                $display("FAIL bp_hold: out_valid=%b s=%h, required out_valid=1 s=%h", out_valid, s, first.s);
            end
        end
        @(posedge clk);
        #1;
        fork
            begin
                send(2'b10, 8'h7F, 8'h00, 1'b0, 1'b0);
                send(2'b11, 8'hAA, 8'h0F, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        tests++;
        if (n_out - start != 4) begin
            fails++;
            $display("FAIL bp_count: %0d results, required 4", n_out - start);
        end
    endtask

    task automatic test_reset_midstream;
        out_ready = 1'b0;
        send(2'b00, 8'h80, 8'h80, 1'b0, 1'b0);
        send(2'b00, 8'h01, 8'h01, 1'b0, 1'b0);
        tests++;
        if (sticky_of !== 1'b1 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: sticky_of=%b out_valid=%b, required 1 1", sticky_of, out_valid);
        end
        rst_n = 1'b0;
        #1;
        q.delete();
        model_carry = 1'b0;
        tests++;
        if ({out_valid, s, cf, of, zf, nf, sticky_of} !== {1'b0, 8'h00, 5'b00000}) begin
            fails++;
            $display("FAIL mid_reset: got ov=%b s=%h flags=%b%b%b%b st=%b, required all 0",
                     out_valid, s, cf, of, zf, nf, sticky_of);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'b00, 8'h01, 8'h01, 1'b1, 1'b1);
        drain();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arith();
        test_clr_sticky();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined successor to the team's 4-bit combinational ALU, generalised to WIDTH bits. Supports the same four operations (add-with-carry, subtract, increment, AND) behind a valid/ready handshake with two register stages. Adds multi-word carry chaining through an internal carry register, Z/N flags and a sticky overflow flag. Sits between the operand sequencer and the result writeback path.

Parameters:
WIDTH, 4, operand/result width in bits (legal range 2 to 64)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block accepts beat when in_valid & in_ready
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  external carry-in; used only by ADD with chain=0
op  input  2  00 ADD, 01 SUB, 10 INC, 11 AND
chain  input  1  1 = carry-in taken from internal carry register (ADD/SUB only)
clr_sticky  input  1  synchronous clear of sticky_of
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts when out_valid & out_ready
s  output  WIDTH  result
cf  output  1  carry out
of  output  1  signed overflow
zf  output  1  result == 0
nf  output  1  result MSB
sticky_of  output  1  OR of of over all results since reset/clear

Behaviour:
- Reset (async assert, sync-safe release): s1_valid=0, out_valid=0, s=0, cf=of=zf=nf=0, sticky_of=0, carry_reg=0. Beats in flight are discarded.
- Stage 1 (S1): registers a, b, cin, op, chain on accept. Stage 2 (S2): registers s and flags; drives outputs.
- Latency: 2 cycles from accept to out_valid with no backpressure; throughput one beat/cycle.
- Advance: s2_adv = !out_valid | out_ready. S1->S2 transfer when s1_valid & s2_adv. in_ready = !s1_valid | s2_adv (combinational; no comb path in_valid->in_ready).
- Outputs hold stable while out_valid & !out_ready. out_valid drops the cycle after a handshake if no new beat enters S2.
- Arithmetic (computed between S1 and S2, WIDTH+1-bit sum, X=operand A, Y=operand B path, c0=carry-in):
  ADD: Y=b, c0 = chain ? carry_reg : cin.
  SUB: Y=~b, c0 = chain ? carry_reg : 1 (cf=1 means no borrow).
  INC: Y=0, c0=1; chain and cin ignored.
  AND: s = a & b; cf=0, of=0.
  Arithmetic ops: s = sum[WIDTH-1:0], cf = sum[WIDTH], of = carry into MSB XOR cf.
- zf = (s==0), nf = s[WIDTH-1], for all ops.
- carry_reg: updated with cf on every S1->S2 transfer of ADD/SUB/INC; unchanged by AND. A chained beat immediately following its predecessor reads the predecessor's carry (predecessor registers into S2 on the same edge the chained beat enters S1). No bubble required.
- sticky_of: set on S1->S2 transfer with of=1; cleared by clr_sticky; if both in same cycle, set wins.
- Wrap-around: results modulo 2^WIDTH; INC of all-ones gives 0, cf=1, zf=1.
- Back-to-back stall: with out_ready low, exactly two beats are buffered (S1, S2); in_ready low thereafter until out_ready returns.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 cin=0 -> after 2 cycles s=0x80, cf=0, of=1, nf=1, zf=0; sticky_of=1.
- SUB a=0x05 b=0x05 -> s=0x00, cf=1, zf=1, of=0; SUB a=0x00 b=0x01 -> s=0xFF, cf=0, nf=1.
- 16-bit add via chain: ADD a=0xFF b=0x01 chain=0 cin=0 then ADD a=0x00 b=0x00 chain=1 back-to-back -> s=0x00 cf=1, then s=0x01 cf=0.
- INC a=0xFF -> s=0x00, cf=1, zf=1; AND a=0xF0 b=0x3C -> s=0x30, cf=0, of=0, carry_reg unchanged.
- Backpressure: stream 4 beats with out_ready=0 -> in_ready falls after 2 accepts, outputs hold first result; release out_ready -> all 4 results in order, none lost or duplicated.
- Reset mid-stream: assert rst_n=0 with 2 beats in flight -> out_valid, flags, sticky_of, carry_reg clear immediately; post-reset chained ADD uses carry 0.
